// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Definitions shared by the bit-serial ALU and its one-bit slice:
//   - opcode encodings carried on the 3-bit control bus
//   - the state type of the serial sequencer
//   - small opcode classification helpers
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam logic [2:0] ALU_ADD = 3'h2;
   localparam logic [2:0] ALU_SUB = 3'h3;
   localparam logic [2:0] ALU_AND = 3'h4;
   localparam logic [2:0] ALU_OR  = 3'h5;
   localparam logic [2:0] ALU_NOR = 3'h6;
   localparam logic [2:0] ALU_XOR = 3'h7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Only ADD and SUB report carry/overflow; everything else forces them low.
   function automatic logic is_arith(input logic [2:0] op);
      return (op == ALU_ADD) || (op == ALU_SUB);
   endfunction

endpackage

// File: rtl/alu_serial_alu1.sv
// -----------------------------------------------------------------------------
// alu1
// One-bit ALU slice. Purely combinational; the caller supplies the carry
// chain state between successive bits.
// Ports:
//   a_i, b_i     operand bits
//   carry_i      carry into this bit
//   control_i    opcode (see alu_pkg)
//   out_o        result bit
//   carry_o      carry out of this bit (0 for non-arithmetic opcodes)
// -----------------------------------------------------------------------------
module alu1
   import alu_pkg::*;
(
   input  logic       a_i,
   input  logic       b_i,
   input  logic       carry_i,
   input  logic [2:0] control_i,
   output logic       out_o,
   output logic       carry_o
);

   logic b_eff;

   // SUB is A + ~B + 1: invert B here, the +1 comes from the initial carry.
   assign b_eff = b_i ^ control_i[0];

   always_comb begin
      out_o   = 1'b0;
      carry_o = 1'b0;
      case (control_i)
         ALU_ADD, ALU_SUB: begin
            out_o   = a_i ^ b_eff ^ carry_i;
            carry_o = (a_i & b_eff) | (carry_i & (a_i ^ b_eff));
         end
         ALU_AND: out_o = a_i & b_i;
         ALU_OR:  out_o = a_i | b_i;
         ALU_NOR: out_o = ~(a_i | b_i);
         ALU_XOR: out_o = a_i ^ b_i;
         default: begin
            // Reserved opcodes produce an all-zero result.
            out_o   = 1'b0;
            carry_o = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu_serial.sv
// -----------------------------------------------------------------------------
// alu_serial
// Bit-serial WIDTH-bit ALU. A full operand pair is taken over a valid/ready
// handshake, pushed LSB first through a single alu1 slice (one bit per
// cycle, carry kept in a register), and the assembled result plus flags are
// offered over a second valid/ready handshake.
// Ports:
//   clock, reset          clock and synchronous active-high reset
//   in_valid / in_ready   operand bundle handshake (ready only in IDLE)
//   A, B, control         operands and opcode, sampled on the accept edge
//   out_valid / out_ready result handshake (valid only in DONE)
//   result                assembled result
//   carryout, overflow    arithmetic flags, 0 for logic/reserved opcodes
//   zero                  result == 0
// -----------------------------------------------------------------------------
module alu_serial
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       control,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carryout,
   output logic             overflow,
   output logic             zero
);

   localparam int             CW       = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [2:0]       ctrl_q, ctrl_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             co_q, co_d;
   logic             ov_q, ov_d;
   logic             zero_q, zero_d;

   logic             accept;
   logic             last_bit;
   logic             slice_out;
   logic             slice_carry;

   assign in_ready = (state_q == IDLE) && !reset;
   assign accept   = in_valid && in_ready;
   assign last_bit = (state_q == RUN) && (cnt_q == LAST_BIT);

   // Operands are held in shift registers so the slice always sees bit 0.
   alu1 u_slice (
      .a_i       (a_q[0]),
      .b_i       (b_q[0]),
      .carry_i   (carry_q),
      .control_i (ctrl_q),
      .out_o     (slice_out),
      .carry_o   (slice_carry)
   );

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept)    state_d = RUN;
         RUN:     if (last_bit)  state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   // ----------------------------------------------------------- datapath
   always_comb begin
      a_d    = a_q;
      b_d    = b_q;
      res_d  = res_q;
      ctrl_d = ctrl_q;
      carry_d = carry_q;
      cnt_d  = cnt_q;
      co_d   = co_q;
      ov_d   = ov_q;
      zero_d = zero_q;

      if (accept) begin
         a_d     = A;
         b_d     = B;
         ctrl_d  = control;
         carry_d = control[0];
         cnt_d   = '0;
      end else if (state_q == RUN) begin
         a_d     = a_q >> 1;
         b_d     = b_q >> 1;
         res_d   = {slice_out, res_q[WIDTH-1:1]};
         carry_d = slice_carry;
         if (last_bit) begin
            // carry_q is the carry into the MSB on this final step.
            co_d   = is_arith(ctrl_q) & slice_carry;
            ov_d   = is_arith(ctrl_q) & (carry_q ^ slice_carry);
            zero_d = (res_d == '0);
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         ctrl_q  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         co_q    <= 1'b0;
         ov_q    <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         ctrl_q  <= ctrl_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         co_q    <= co_d;
         ov_q    <= ov_d;
         zero_q  <= zero_d;
      end
   end

   assign out_valid = (state_q == DONE);
   assign result    = res_q;
   assign carryout  = co_q;
   assign overflow  = ov_q;
   assign zero      = zero_q;

endmodule
